// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared definitions for the iterative multiply unit. Holds the
//            default operand width, the multiply op encodings and the FSM
//            state type.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

  localparam int c_XLEN_DEFAULT = 32;

  // Operation encodings, matching the RV32M funct3 low bits
  localparam logic [1:0] c_OP_MUL    = 2'b00;
  localparam logic [1:0] c_OP_MULH   = 2'b01;
  localparam logic [1:0] c_OP_MULHSU = 2'b10;
  localparam logic [1:0] c_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_iter_unit
// Purpose  : Iterative shift-add multiplier supporting MUL/MULH/MULHSU/MULHU.
//            Operands are converted to magnitudes on accept, one multiplier
//            bit is consumed per cycle for XLEN cycles, and the signed
//            product half is registered on completion.
// Ports    : clk       - clock, all state updates on rising edge
//            rst       - synchronous reset, active low
//            start_mul - one-cycle request to begin a multiply
//            op        - 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//            a, b      - rs1 / rs2 operands
//            rd_in     - destination register tag
//            busy      - high while a multiply is in flight (CALC or DONE)
//            done_mul  - one-cycle pulse, result/rd_out valid
//            result    - selected product half (held until next DONE)
//            rd_out    - latched destination tag (held until next DONE)
// Revision : 1.0 - initial release
// ============================================================================
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int XLEN = c_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_mul,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done_mul,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(XLEN - 1);

  mul_state_e          r_state;
  mul_state_e          w_state_next;
  logic                w_accept;

  logic [1:0]          r_op;
  logic [4:0]          r_rd;
  logic [XLEN-1:0]     r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic                r_neg;
  logic [2*XLEN-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd_out;

  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_acc_step;
  logic [2*XLEN-1:0]   w_prod;
  logic                w_last;

  // --------------------------------------------------------------------------
  // Operand conditioning. Negating the most negative value wraps back to
  // itself, which is exactly the correct unsigned magnitude.
  // --------------------------------------------------------------------------
  always_comb begin
    w_a_signed = (op == c_OP_MULH) || (op == c_OP_MULHSU);
    w_b_signed = (op == c_OP_MULH);
    w_a_neg    = w_a_signed & a[XLEN-1];
    w_b_neg    = w_b_signed & b[XLEN-1];
    w_a_mag    = w_a_neg ? (~a + XLEN'(1)) : a;
    w_b_mag    = w_b_neg ? (~b + XLEN'(1)) : b;
  end

  // --------------------------------------------------------------------------
  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  // After XLEN steps the accumulator holds the full unsigned product.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                 (r_mplier[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
    w_acc_step = {w_sum, r_acc[XLEN-1:1]};
    w_prod     = r_neg ? (~w_acc_step + (2*XLEN)'(1)) : w_acc_step;
    w_last     = (r_cnt == c_CNT_LAST);
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done_mul     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_mul) begin
          w_accept     = 1'b1;
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy     = 1'b1;
        done_mul = 1'b1;
        // A new request here starts immediately, no idle bubble
        if (start_mul) begin
          w_accept     = 1'b1;
          w_state_next = ST_CALC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op     <= 2'b00;
      r_rd     <= 5'd0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_rd_out <= 5'd0;
    end else if (w_accept) begin
      r_op     <= op;
      r_rd     <= rd_in;
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_neg    <= w_a_neg ^ w_b_neg;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == ST_CALC) begin
      r_acc    <= w_acc_step;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= (r_op == c_OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        r_rd_out <= r_rd;
      end
    end
  end

  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule : mul_iter_unit
`default_nettype wire

// File: tb/tb_mul_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_iter_unit
// Purpose  : Directed self-checking bench for mul_iter_unit with
//            hand-computed expected products, latency, busy window,
//            ignored/back-to-back starts and mid-operation reset.
// Ports    : (testbench - none)
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_iter_unit;
  import mul_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_mul;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done_mul;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mul_iter_unit #(.XLEN(XLEN)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start_mul (start_mul),
    .op        (op),
    .a         (a),
    .b         (b),
    .rd_in     (rd_in),
    .busy      (busy),
    .done_mul  (done_mul),
    .result    (result),
    .rd_out    (rd_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called just after a negedge; returns just after the next negedge
  // (cycle 1 of the operation when accepted).
  task automatic issue(input logic [1:0] o, input logic [XLEN-1:0] va,
                       input logic [XLEN-1:0] vb, input logic [4:0] rd);
    start_mul = 1'b1;
    op        = o;
    a         = va;
    b         = vb;
    rd_in     = rd;
    @(negedge clk);
    start_mul = 1'b0;
  endtask

  // Counts cycles since the start cycle until done_mul, bounded.
  task automatic wait_done(input int first, output int lat, output int busy_n);
    lat    = first;
    busy_n = 0;
    while (!done_mul && lat < 60) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_n++;
  endtask

  task automatic run_vec(input string tag, input logic [1:0] o,
                         input logic [XLEN-1:0] va, input logic [XLEN-1:0] vb,
                         input logic [4:0] rd, input logic [XLEN-1:0] exp);
    int lat;
    int bn;
    issue(o, va, vb, rd);
    wait_done(1, lat, bn);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd"}, rd_out, rd);
    check({tag, "_latency"}, lat, 33);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int bn;
    int done_seen;

    rst       = 1'b0;
    start_mul = 1'b0;
    op        = c_OP_MUL;
    a         = '0;
    b         = '0;
    rd_in     = 5'd0;
    repeat (3) @(negedge clk);

    check("rst_busy",   busy,     0);
    check("rst_done",   done_mul, 0);
    check("rst_result", result,   0);
    check("rst_rd",     rd_out,   0);
    rst = 1'b1;
    @(negedge clk);

    // Basic MUL with latency and busy window
    issue(c_OP_MUL, 32'd7, 32'd6, 5'd5);
    wait_done(1, lat, bn);
    check("mul7x6_result",  result, 32'h0000002A);
    check("mul7x6_rd",      rd_out, 5'd5);
    check("mul7x6_latency", lat, 33);
    check("mul7x6_busy",    bn, 33);
    @(negedge clk);
    check("mul7x6_idle_busy", busy, 0);
    check("mul7x6_idle_done", done_mul, 0);

    run_vec("mulh_m1",     c_OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000);
    run_vec("mulhu_m1",    c_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE);
    run_vec("mul_m1",      c_OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000001);
    run_vec("mulhsu_m1x2", c_OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd4,  32'hFFFFFFFF);
    run_vec("mulh_min",    c_OP_MULH,   32'h80000000, 32'h80000000, 5'd31, 32'h40000000);
    run_vec("mulh_m3x5",   c_OP_MULH,   32'hFFFFFFFD, 32'd5,        5'd6,  32'hFFFFFFFF);
    run_vec("mul_m3x5",    c_OP_MUL,    32'hFFFFFFFD, 32'd5,        5'd7,  32'hFFFFFFF1);
    run_vec("mulhsu_min",  c_OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h80000000);

    // Start during CALC must be ignored
    issue(c_OP_MUL, 32'd3, 32'd4, 5'd7);
    repeat (4) @(negedge clk);
    issue(c_OP_MULHU, 32'd100, 32'd100, 5'd9);
    wait_done(6, lat, bn);
    check("ign_result",  result, 32'd12);
    check("ign_rd",      rd_out, 5'd7);
    check("ign_latency", lat, 33);
    repeat (3) @(negedge clk);
    check("ign_hold_result", result, 32'd12);
    check("ign_hold_busy",   busy, 0);

    // Back-to-back start in the DONE cycle
    issue(c_OP_MUL, 32'd9, 32'd9, 5'd1);
    wait_done(1, lat, bn);
    check("b2b1_result",  result, 32'd81);
    check("b2b1_latency", lat, 33);
    issue(c_OP_MUL, 32'd10, 32'd11, 5'd2);
    check("b2b2_busy",        busy, 1);
    check("b2b2_hold_result", result, 32'd81);
    check("b2b2_hold_rd",     rd_out, 5'd1);
    wait_done(1, lat, bn);
    check("b2b2_result",  result, 32'd110);
    check("b2b2_rd",      rd_out, 5'd2);
    check("b2b2_latency", lat, 33);
    @(negedge clk);

    // Reset at cycle 10 of CALC, with start held during reset
    issue(c_OP_MUL, 32'd5, 32'd5, 5'd3);
    repeat (9) @(negedge clk);
    rst       = 1'b0;
    start_mul = 1'b1;
    @(negedge clk);
    check("abort_busy",   busy, 0);
    check("abort_done",   done_mul, 0);
    check("abort_result", result, 0);
    check("abort_rd",     rd_out, 0);
    rst       = 1'b1;
    start_mul = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_mul || busy) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", done_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mul_iter_unit
`default_nettype wire
